rob_ctrl: RTL and testbench
===========================

# rob_ctrl

Allocation and commit controller for the 4-bank reorder buffer ring: owns head/tail row pointers, per-entry busy/exception state and the occupancy count. Dispatch allocates one 4-wide row per cycle and returns its tag. Writeback clears busy bits per entry. A row commits when all four entries are done. An exception at the head row triggers a one-cycle flush that empties the ring. It sits between rename/dispatch and the ROB banks, and drives their write-enable and read-enable.

## Interface
Parameters:
- `ROW_W`, default 3: row index width; ring holds 2^ROW_W rows (8).
- `NBANK`, default 4: entries per row; fixed at 4.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_dis_req`  in  1  dispatch group valid this cycle.
- `i_dis_val4x`  in  4  per-lane valid of the dispatch group; invalid lanes are allocated already done.
- `o_dis_ready`  out  1  a row is free; dispatch accepted when `i_dis_req & o_dis_ready`.
- `o_dis_tag`  out  ROW_W  row index the next dispatch receives (equals tail).
- `o_dis_we`  out  1  write strobe to ROB banks (`i_dis_req & o_dis_ready`).
- `i_wb_en4x`  in  4  writeback port enables.
- `i_wb_tag4x`  in  4*(ROW_W+2)  per port: {row, bank}.
- `i_wb_exc4x`  in  4  per port: entry raised an exception.
- `o_com_en`  out  1  head row commits this cycle (read-enable to banks).
- `o_com_tag`  out  ROW_W  head row index.
- `o_flush`  out  1  flush pulse.
- `o_flush_tag`  out  ROW_W  row holding the exception.
- `o_exc_bank4x`  out  4  exception bits of the flushed row; valid with `o_flush`.
- `o_count`  out  ROW_W+1  occupied rows, 0..2^ROW_W.

## Operation
- Per entry state: `val` (row allocated), `busy`, `exc`. Per row state: `val` is shared across its 4 entries.
- Dispatch accept: row[tail].val←1; for each bank b, busy[b]←i_dis_val4x[b], exc[b]←0. Tail advances mod 2^ROW_W.
- Writeback: for each enabled port, if the target row is valid then busy←0 and exc←exc|i_wb_exc.
  - A writeback to an invalid row is ignored.
  - Multiple ports may target different entries in the same cycle; all apply.
  - Two ports hitting the same entry: OR of the exc bits.
- Head complete: row[head].val & no busy entries in that row.
  - NORMAL state, head complete, no exc in the row: `o_com_en`=1 combinationally. At the edge: row invalidated, head advances, count decrements.
  - NORMAL state, head complete, any exc bit set: `o_com_en`=0, next state FLUSH, `o_flush_tag`/`o_exc_bank4x` latched.
- FSM:
  - NORMAL→FLUSH on a head exception.
  - FLUSH: `o_flush`=1, `o_dis_ready`=0, writebacks ignored. At the edge: all val/busy/exc cleared, head=tail=0, count=0, →NORMAL.
- Count on the same edge: +1 on dispatch, −1 on commit; both together leave it unchanged.
- Full (count==2^ROW_W): `o_dis_ready`=0 even if a commit occurs this cycle (no bypass).
- Empty: no commit. A row dispatched in cycle t is never committable before cycle t+1.
- Writeback to the row being dispatched in the same cycle: dispatch wins.
- Reset: overrides everything, including mid-flush. Outputs after reset: `o_dis_ready`=1, `o_dis_tag`=0, `o_com_en`=0, `o_com_tag`=0, `o_flush`=0, `o_flush_tag`=0, `o_exc_bank4x`=0, `o_count`=0, state NORMAL.

## Timing
- Dispatch→tag: `o_dis_tag` is valid in the accepting cycle; the new tail is visible next cycle.
- Writeback at edge t → `o_com_en` earliest in cycle t+1 if that row is head.
- Commit throughput: one row per cycle.
- Exception path:
  - Writeback with exc at edge t → FLUSH entered at edge t+1 (head complete seen in cycle t+1).
  - `o_flush` high in cycle t+2.
  - `o_dis_ready`=1 again in cycle t+3.
- `o_dis_ready` and `o_count` are functions of registered state only. `o_com_en` is combinational from registered state.

## Structure
- Shared package `rob_pkg`: `NBANK`=4, `ROW_W`, FSM state encoding (NORMAL, FLUSH), and a tag-packing helper giving {row, bank} width ROW_W+2.
- Sub-module `rob_row_status`, one instance per row: holds val/busy4/exc4 and decodes the 4 writeback ports against its own row index. Outputs `done` and `exc_any`.

## Test plan
- Reset, then dispatch 8 rows with `i_dis_val4x`=4'hF → tags 0..7; `o_count`=8, `o_dis_ready`=0 on the 9th request, no `o_dis_we`.
- Fill 2 rows; write back row 1 fully, then row 0 → no commit until row 0 is complete; then `o_com_en` with tag 0, then tag 1 on consecutive cycles; `o_count`=0.
- Dispatch with `i_dis_val4x`=4'b0101; write back banks 0 and 2 only → row commits one cycle after the second writeback.
- Full ring, head complete: assert dispatch and commit in the same cycle → commit occurs, dispatch is not accepted, count 8→7; next cycle dispatch is accepted with tag 0 (wrap).
- Write back row 3 bank 2 with exc; rows 0–2 commit → `o_flush` pulse with `o_flush_tag`=3, `o_exc_bank4x`=4'b0100; next cycle `o_count`=0 and `o_dis_tag`=0.
- Assert `i_rst` during the FLUSH cycle and during a writeback → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared constants, FSM encoding and tag helper for the ROB controller
// Purpose: common definitions imported by rob_row_status and rob_ctrl.
// Contents: NBANK (entries per row), ROW_W (default row index width),
//           rob_state_t (NORMAL/FLUSH), pack_tag() building a {row, bank} tag.
package rob_pkg;

    localparam int NBANK = 4;
    localparam int ROW_W = 3;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } rob_state_t;

    // Writeback tag layout: row index in the upper bits, bank in the low two.
    function automatic logic [ROW_W+1:0] pack_tag(input logic [ROW_W-1:0] row,
                                                  input logic [1:0]       bank);
        return {row, bank};
    endfunction

endpackage

// File: rtl/rob_row_status.sv
// rtl/rob_row_status.sv - valid/busy/exception state for one ROB row
// Purpose: tracks one 4-entry row and decodes the writeback ports against its own index.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           flush: clear the row
//   alloc         dispatch writes this row; alloc_val gives per-lane validity
//   com           row commits this cycle
//   wb_en/wb_tag/wb_exc  the writeback ports ({row, bank} tags)
//   val           row allocated
//   done          allocated and no entry busy
//   exc_any, exc  exception summary and per-bank exception bits
module rob_row_status
    import rob_pkg::*;
#(
    parameter int ROW_W   = 3,
    parameter int ROW_IDX = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        alloc,
    input  logic [NBANK-1:0]            alloc_val,
    input  logic                        com,
    input  logic [NBANK-1:0]            wb_en,
    input  logic [NBANK*(ROW_W+2)-1:0]  wb_tag,
    input  logic [NBANK-1:0]            wb_exc,
    output logic                        val,
    output logic                        done,
    output logic                        exc_any,
    output logic [NBANK-1:0]            exc
);

    localparam int TW = ROW_W + 2;
    localparam logic [ROW_W-1:0] MY_ROW = ROW_W'(ROW_IDX);

    logic [NBANK-1:0] busy;
    logic [NBANK-1:0] busy_n;
    logic [NBANK-1:0] exc_n;

    // All ports apply in the same cycle; two ports on one entry OR their exc bits.
    always_comb begin
        logic [1:0] bk;
        busy_n = busy;
        exc_n  = exc;
        bk     = '0;
        for (int p = 0; p < NBANK; p++) begin
            bk = wb_tag[p*TW +: 2];
            if (wb_en[p] && (wb_tag[p*TW+2 +: ROW_W] == MY_ROW)) begin
                busy_n[bk] = 1'b0;
                exc_n[bk]  = exc_n[bk] | wb_exc[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            val  <= 1'b0;
            busy <= '0;
            exc  <= '0;
        end else if (alloc) begin
            // Dispatch wins over any same-cycle writeback to this row.
            val  <= 1'b1;
            busy <= alloc_val;
            exc  <= '0;
        end else if (com) begin
            val  <= 1'b0;
        end else if (val) begin
            // Writebacks to an unallocated row are dropped.
            busy <= busy_n;
            exc  <= exc_n;
        end
    end

    assign done    = val && (busy == '0);
    assign exc_any = |exc;

endmodule

// File: rtl/rob_ctrl.sv
// rtl/rob_ctrl.sv - allocation/commit/flush controller for the 4-bank ROB ring
// Purpose: owns head/tail pointers, occupancy count and the NORMAL/FLUSH FSM;
//          one rob_row_status instance per ring row.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_dis_req, i_dis_val4x             dispatch group request and lane valids
//   o_dis_ready, o_dis_tag, o_dis_we   dispatch handshake, allocated row, bank write strobe
//   i_wb_en4x, i_wb_tag4x, i_wb_exc4x  writeback ports ({row, bank} tags)
//   o_com_en, o_com_tag                head row commit (bank read-enable) and its index
//   o_flush, o_flush_tag, o_exc_bank4x flush pulse, excepting row and its exc bits
//   o_count                            occupied rows
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int ROW_W = 3,
    parameter int NBANK = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_dis_req,
    input  logic [NBANK-1:0]            i_dis_val4x,
    output logic                        o_dis_ready,
    output logic [ROW_W-1:0]            o_dis_tag,
    output logic                        o_dis_we,
    input  logic [NBANK-1:0]            i_wb_en4x,
    input  logic [NBANK*(ROW_W+2)-1:0]  i_wb_tag4x,
    input  logic [NBANK-1:0]            i_wb_exc4x,
    output logic                        o_com_en,
    output logic [ROW_W-1:0]            o_com_tag,
    output logic                        o_flush,
    output logic [ROW_W-1:0]            o_flush_tag,
    output logic [NBANK-1:0]            o_exc_bank4x,
    output logic [ROW_W:0]              o_count
);

    localparam int NROW = 1 << ROW_W;

    rob_state_t         state, state_n;
    logic [ROW_W-1:0]   head, tail;
    logic [ROW_W:0]     count;
    logic [ROW_W-1:0]   flush_tag;
    logic [NBANK-1:0]   flush_exc;

    logic [NROW-1:0]    row_val, row_done, row_exc_any;
    logic [NBANK-1:0]   row_exc [NROW];

    logic full, head_done, head_exc, accept, commit, go_flush;

    assign full      = (count == (ROW_W+1)'(NROW));
    assign head_done = row_done[head];
    assign head_exc  = row_exc_any[head];

    // Full blocks dispatch even when the head commits this cycle (no bypass).
    assign o_dis_ready = (state == ST_NORMAL) && !full;
    assign accept      = i_dis_req && o_dis_ready;
    assign commit      = (state == ST_NORMAL) && head_done && !head_exc;
    assign go_flush    = (state == ST_NORMAL) && head_done && head_exc;

    for (genvar r = 0; r < NROW; r++) begin : g_row
        rob_row_status #(
            .ROW_W   (ROW_W),
            .ROW_IDX (r)
        ) u_row (
            .clk       (i_clk),
            .rst       (i_rst),
            .clr       (state == ST_FLUSH),
            .alloc     (accept && (tail == ROW_W'(r))),
            .alloc_val (i_dis_val4x),
            .com       (commit && (head == ROW_W'(r))),
            .wb_en     (i_wb_en4x),
            .wb_tag    (i_wb_tag4x),
            .wb_exc    (i_wb_exc4x),
            .val       (row_val[r]),
            .done      (row_done[r]),
            .exc_any   (row_exc_any[r]),
            .exc       (row_exc[r])
        );
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_NORMAL: if (go_flush) state_n = ST_FLUSH;
            ST_FLUSH:  state_n = ST_NORMAL;
            default:   state_n = ST_NORMAL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_NORMAL;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            flush_tag <= '0;
            flush_exc <= '0;
        end else begin
            state <= state_n;
            if (state == ST_FLUSH) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (accept) tail <= tail + 1'b1;
                if (commit) head <= head + 1'b1;
                count <= count + (ROW_W+1)'(accept) - (ROW_W+1)'(commit);
            end
            if (go_flush) begin
                flush_tag <= head;
                flush_exc <= row_exc[head];
            end
        end
    end

    assign o_dis_tag    = tail;
    assign o_dis_we     = accept;
    assign o_com_en     = commit;
    assign o_com_tag    = head;
    assign o_flush      = (state == ST_FLUSH);
    assign o_flush_tag  = flush_tag;
    assign o_exc_bank4x = flush_exc;
    assign o_count      = count;

    logic unused_ok;
    assign unused_ok = ^row_val;

endmodule

// File: tb/tb_rob_ctrl.sv
// tb/tb_rob_ctrl.sv - directed self-checking bench for rob_ctrl
module tb_rob_ctrl;
    import rob_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_dis_req;
    logic [3:0]  i_dis_val4x;
    logic        o_dis_ready;
    logic [2:0]  o_dis_tag;
    logic        o_dis_we;
    logic [3:0]  i_wb_en4x;
    logic [19:0] i_wb_tag4x;
    logic [3:0]  i_wb_exc4x;
    logic        o_com_en;
    logic [2:0]  o_com_tag;
    logic        o_flush;
    logic [2:0]  o_flush_tag;
    logic [3:0]  o_exc_bank4x;
    logic [3:0]  o_count;

    int total = 0;
    int bad   = 0;

    rob_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_dis_req    (i_dis_req),
        .i_dis_val4x  (i_dis_val4x),
        .o_dis_ready  (o_dis_ready),
        .o_dis_tag    (o_dis_tag),
        .o_dis_we     (o_dis_we),
        .i_wb_en4x    (i_wb_en4x),
        .i_wb_tag4x   (i_wb_tag4x),
        .i_wb_exc4x   (i_wb_exc4x),
        .o_com_en     (o_com_en),
        .o_com_tag    (o_com_tag),
        .o_flush      (o_flush),
        .o_flush_tag  (o_flush_tag),
        .o_exc_bank4x (o_exc_bank4x),
        .o_count      (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_dis_req   = 1'b0;
        i_dis_val4x = 4'h0;
        i_wb_en4x   = 4'h0;
        i_wb_tag4x  = '0;
        i_wb_exc4x  = 4'h0;
    endtask

    // Advance one clock; inputs are applied and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
        idle();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb_port(input int p, input int row, input int bank, input bit e);
        logic [4:0] t;
        t = pack_tag(3'(row), 2'(bank));
        i_wb_en4x[p]          = 1'b1;
        i_wb_tag4x[p*5 +: 5]  = t;
        i_wb_exc4x[p]         = e;
    endtask

    task automatic wb_row(input int row, input logic [3:0] e);
        for (int b = 0; b < 4; b++) wb_port(b, row, b, e[b]);
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic dispatch_n(input int n);
        for (int k = 0; k < n; k++) begin
            i_dis_req   = 1'b1;
            i_dis_val4x = 4'hF;
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"}, o_dis_ready, 1);
        check({pfx, "_dis_tag"}, o_dis_tag, 0);
        check({pfx, "_com_en"}, o_com_en, 0);
        check({pfx, "_com_tag"}, o_com_tag, 0);
        check({pfx, "_flush"}, o_flush, 0);
        check({pfx, "_flush_tag"}, o_flush_tag, 0);
        check({pfx, "_exc_bank"}, o_exc_bank4x, 0);
        check({pfx, "_count"}, o_count, 0);
    endtask

    initial begin
        idle();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        settle();
        check_reset_outputs("rst");

        // Fill the ring: tags 0..7, then the 9th request is refused.
        for (int k = 0; k < 8; k++) begin
            i_dis_req   = 1'b1;
            i_dis_val4x = 4'hF;
            settle();
            check("fill_tag", o_dis_tag, k);
            check("fill_we", o_dis_we, 1);
            tick();
        end
        i_dis_req   = 1'b1;
        i_dis_val4x = 4'hF;
        settle();
        check("full_count", o_count, 8);
        check("full_ready", o_dis_ready, 0);
        check("full_we", o_dis_we, 0);
        check("full_no_com", o_com_en, 0);
        tick();
        check("full_count_hold", o_count, 8);

        // Out-of-order completion: row 1 done first, commit waits for row 0.
        do_reset();
        dispatch_n(2);
        wb_row(1, 4'h0);
        settle();
        check("ooo_no_com_a", o_com_en, 0);
        tick();
        wb_row(0, 4'h0);
        settle();
        check("ooo_no_com_b", o_com_en, 0);
        tick();
        check("ooo_com0_en", o_com_en, 1);
        check("ooo_com0_tag", o_com_tag, 0);
        check("ooo_count2", o_count, 2);
        tick();
        check("ooo_com1_en", o_com_en, 1);
        check("ooo_com1_tag", o_com_tag, 1);
        check("ooo_count1", o_count, 1);
        tick();
        check("ooo_idle", o_com_en, 0);
        check("ooo_count0", o_count, 0);

        // Sparse lanes: only banks 0 and 2 need writeback.
        do_reset();
        i_dis_req   = 1'b1;
        i_dis_val4x = 4'b0101;
        tick();
        check("sparse_busy", o_com_en, 0);
        wb_port(0, 0, 0, 1'b0);
        tick();
        check("sparse_half", o_com_en, 0);
        wb_port(0, 0, 2, 1'b0);
        tick();
        check("sparse_com", o_com_en, 1);
        check("sparse_tag", o_com_tag, 0);
        tick();
        check("sparse_count", o_count, 0);

        // Full ring with head complete: commit happens, dispatch refused, then wrap.
        do_reset();
        dispatch_n(8);
        wb_row(0, 4'h0);
        tick();
        i_dis_req   = 1'b1;
        i_dis_val4x = 4'hF;
        settle();
        check("fc_com", o_com_en, 1);
        check("fc_ready", o_dis_ready, 0);
        check("fc_we", o_dis_we, 0);
        tick();
        i_dis_req   = 1'b1;
        i_dis_val4x = 4'hF;
        settle();
        check("fc_count7", o_count, 7);
        check("fc_ready2", o_dis_ready, 1);
        check("fc_wrap_tag", o_dis_tag, 0);
        check("fc_we2", o_dis_we, 1);
        tick();
        check("fc_count8", o_count, 8);

        // Exception on row 3 bank 2 flushes after rows 0..2 commit.
        do_reset();
        dispatch_n(4);
        wb_row(3, 4'b0100);
        tick();
        wb_row(0, 4'h0);
        tick();
        wb_row(1, 4'h0);
        settle();
        check("exc_com0", o_com_en, 1);
        check("exc_com0_tag", o_com_tag, 0);
        tick();
        wb_row(2, 4'h0);
        settle();
        check("exc_com1_tag", o_com_tag, 1);
        tick();
        check("exc_com2", o_com_en, 1);
        check("exc_com2_tag", o_com_tag, 2);
        tick();
        check("exc_head_no_com", o_com_en, 0);
        check("exc_no_flush_yet", o_flush, 0);
        check("exc_count1", o_count, 1);
        tick();
        i_dis_req   = 1'b1;
        i_dis_val4x = 4'hF;
        settle();
        check("exc_flush", o_flush, 1);
        check("exc_flush_tag", o_flush_tag, 3);
        check("exc_bank", o_exc_bank4x, 4'b0100);
        check("exc_ready", o_dis_ready, 0);
        check("exc_we", o_dis_we, 0);
        tick();
        check("post_flush", o_flush, 0);
        check("post_count", o_count, 0);
        check("post_dis_tag", o_dis_tag, 0);
        check("post_ready", o_dis_ready, 1);
        check("post_com", o_com_en, 0);

        // Reset during the FLUSH cycle.
        do_reset();
        dispatch_n(1);
        wb_row(0, 4'b0010);
        tick();
        tick();
        settle();
        check("rf_flush", o_flush, 1);
        check("rf_flush_tag", o_flush_tag, 0);
        check("rf_exc_bank", o_exc_bank4x, 4'b0010);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        settle();
        check_reset_outputs("rf");

        // Reset during a writeback: rows are cleared, nothing commits afterwards.
        dispatch_n(2);
        wb_row(0, 4'h0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        settle();
        check_reset_outputs("rw");
        tick();
        check("rw_no_com", o_com_en, 0);
        check("rw_count", o_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
